// File: rtl/product_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the multiplier product.
// One iteration per clock; the result is offered on a valid/ready output port.
module product_bcd_conv #(
    parameter int IN_WIDTH = 8,
    parameter int NDIG     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] io_Product,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [3:0]          bcd_hundreds,
    output logic [3:0]          bcd_tens,
    output logic [3:0]          bcd_ones,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int DIG_W = 4 * NDIG;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_sr_q, bin_sr_d;
    logic [DIG_W-1:0]    dig_sr_q, dig_sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIG_W-1:0]    bcd_q, bcd_d;

    logic [DIG_W-1:0]          dig_adj;
    logic [DIG_W+IN_WIDTH-1:0] shifted;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid depend only on state, never on the partner's signal.
    always_comb begin
        dig_adj = dig_sr_q;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_sr_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_sr_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {dig_adj, bin_sr_q} << 1;
    end

    always_comb begin
        state_d  = state_q;
        bin_sr_d = bin_sr_q;
        dig_sr_d = dig_sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_sr_d = io_Product;
                    dig_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                dig_sr_d = shifted[DIG_W+IN_WIDTH-1 -: DIG_W];
                bin_sr_d = shifted[IN_WIDTH-1:0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                    // Capture the post-shift digits, which hold the final answer.
                    bcd_d   = shifted[DIG_W+IN_WIDTH-1 -: DIG_W];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            bin_sr_q <= '0;
            dig_sr_q <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            bin_sr_q <= bin_sr_d;
            dig_sr_q <= dig_sr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q == SHIFT);
    assign dbg_state    = state_q;
    assign bcd_hundreds = bcd_q[11:8];
    assign bcd_tens     = bcd_q[7:4];
    assign bcd_ones     = bcd_q[3:0];

endmodule

// File: tb/tb_product_bcd_conv.sv
// Bench for product_bcd_conv: directed conversions checked through an expected
// queue popped by a monitor on every output handshake.
module tb_product_bcd_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_product;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  always #5 clk = ~clk;

  product_bcd_conv #(.IN_WIDTH(8), .NDIG(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_Product   (io_product),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal digits via division, packed as {hundreds, tens, ones}.
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic send(input logic [7:0] v, input logic [11:0] e);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      io_product = v;
      in_valid = 1'b1;
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 40) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %0h required none", {bcd_hundreds, bcd_tens, bcd_ones});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 32'({bcd_hundreds, bcd_tens, bcd_ones}), 32'(mon_exp));
      end
    end
  end

  initial begin
    int lat;
    int busy_cnt;
    int n;

    rst = 1'b0;
    io_product = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      io_product = 8'($urandom_range(0, 255));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_digits", 32'({bcd_hundreds, bcd_tens, bcd_ones}), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("idle_after_rst", 32'(dbg_state), 32'd0);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 15x15: latency and busy window.
    send(8'd225, 12'h225);
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd8);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    tick();
    check("in_ready_after_done", 32'(in_ready), 32'd1);
    drain();

    // Boundary values.
    send(8'd0,   12'h000);
    send(8'd9,   12'h009);
    send(8'd10,  12'h010);
    send(8'd99,  12'h099);
    send(8'd100, 12'h100);
    send(8'd255, 12'h255);
    drain();

    // Full sweep against the division model.
    for (int v = 0; v < 256; v++) begin
      send(8'(v), ref_bcd(v));
    end
    drain();

    // Backpressure with ignored inputs.
    out_ready = 1'b0;
    send(8'd49, 12'h049);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      io_product = 8'd7;
      in_valid = (i % 2 == 0);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_digits", 32'({bcd_hundreds, bcd_tens, bcd_ones}), 32'h049);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", 32'(in_ready), 32'd1);
    send(8'd7, 12'h007);
    drain();

    // Input changes during conversion, held through the DONE cycle.
    send(8'd144, 12'h144);
    io_product = 8'd3;
    in_valid = 1'b1;
    repeat (9) tick();
    in_valid = 1'b0;
    check("no_bypass_idle", 32'(in_ready), 32'd1);
    check("no_bypass_busy", 32'(busy), 32'd0);
    repeat (12) tick();
    drain();

    // Reset after four shifts discards the conversion.
    send(8'd200, 12'h200);
    repeat (4) tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_digits", 32'({bcd_hundreds, bcd_tens, bcd_ones}), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (12) tick();
    check("midrst_no_valid", 32'(out_valid), 32'd0);
    send(8'd81, 12'h081);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
